// File: rtl/store_aligner.sv
// Store data aligner: narrows and lane-replicates register data, builds byte enables,
// and buffers formatted stores in a two-entry in-order FIFO with misalignment reporting.
module store_aligner #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_SIZE-1:0] in_addr,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic [1:0]           in_size,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_SIZE-1:0] out_addr,
    output logic [DATA_SIZE-1:0] out_wdata,
    output logic [3:0]           out_be,
    output logic                 align_err,
    output logic [ADDR_SIZE-1:0] err_addr,
    output logic                 err_cause
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

    fifo_state_t state, state_next;

    logic [ADDR_SIZE-1:0] word_addr;
    logic [DATA_SIZE-1:0] fmt_wdata;
    logic [3:0]           fmt_be;
    logic                 legal;
    logic                 accept, push, reject, pop;
    logic                 load_head, load_tail, shift;

    logic [ADDR_SIZE-1:0] tail_addr;
    logic [DATA_SIZE-1:0] tail_wdata;
    logic [3:0]           tail_be;

    assign word_addr = {in_addr[ADDR_SIZE-1:2], 2'b00};
    assign in_ready  = ~rst & (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready & ~flush;
    assign push      = accept & legal;
    assign reject    = accept & ~legal;
    assign pop       = out_valid & out_ready;

    always_comb begin
        fmt_wdata = in_data;
        fmt_be    = 4'b1111;
        legal     = 1'b0;
        case (in_size)
            2'b00: begin
                fmt_wdata = {4{in_data[7:0]}};
                fmt_be    = 4'b0001 << in_addr[1:0];
                legal     = 1'b1;
            end
            2'b01: begin
                fmt_wdata = {2{in_data[15:0]}};
                fmt_be    = in_addr[1] ? 4'b1100 : 4'b0011;
                legal     = ~in_addr[0];
            end
            2'b10: begin
                legal = (in_addr[1:0] == 2'b00);
            end
            default: legal = 1'b0;
        endcase
    end

    // Head registers drive the outputs directly; the tail slot only exists while FULL.
    always_comb begin
        state_next = state;
        load_head  = 1'b0;
        load_tail  = 1'b0;
        shift      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: if (push) begin
                    state_next = ONE;
                    load_head  = 1'b1;
                end
                ONE: case ({push, pop})
                    2'b10: begin
                        state_next = FULL;
                        load_tail  = 1'b1;
                    end
                    2'b01: state_next = EMPTY;
                    2'b11: load_head = 1'b1;
                    default: ;
                endcase
                FULL: if (pop) begin
                    state_next = ONE;
                    shift      = 1'b1;
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            out_addr   <= '0;
            out_wdata  <= '0;
            out_be     <= '0;
            tail_addr  <= '0;
            tail_wdata <= '0;
            tail_be    <= '0;
            align_err  <= 1'b0;
            err_addr   <= '0;
            err_cause  <= 1'b0;
        end else begin
            state     <= state_next;
            align_err <= reject;
            if (reject) begin
                err_addr  <= in_addr;
                err_cause <= (in_size == 2'b11);
            end
            if (load_head) begin
                out_addr  <= word_addr;
                out_wdata <= fmt_wdata;
                out_be    <= fmt_be;
            end else if (shift) begin
                out_addr  <= tail_addr;
                out_wdata <= tail_wdata;
                out_be    <= tail_be;
            end
            if (load_tail) begin
                tail_addr  <= word_addr;
                tail_wdata <= fmt_wdata;
                tail_be    <= fmt_be;
            end
        end
    end

endmodule

// File: tb/tb_store_aligner.sv
// Directed self-checking bench for store_aligner: formatting, errors, FIFO order,
// backpressure, flush and reset.
module tb_store_aligner;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_addr, in_data, out_addr, out_wdata, err_addr;
    logic [1:0]  in_size;
    logic [3:0]  out_be;
    logic        align_err, err_cause;

    int n_checks = 0;
    int n_fail   = 0;

    store_aligner #(.ADDR_SIZE(32), .DATA_SIZE(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_data(in_data), .in_size(in_size),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_wdata(out_wdata), .out_be(out_be),
        .align_err(align_err), .err_addr(err_addr), .err_cause(err_cause)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d);
        in_valid = v;
        in_size  = sz;
        in_addr  = a;
        in_data  = d;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_addr"}, out_addr, a);
        chk({tag, "_wdata"}, out_wdata, d);
        chk({tag, "_be"}, 32'(out_be), 32'(be));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 2'b10, 32'h0000_1000, 32'hCAFE_F00D);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_align_err", 32'(align_err), 32'd0);
        chk("rst_out_addr", out_addr, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        rst = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // byte at offset 3
        drive(1'b1, 2'b00, 32'h0000_1003, 32'hAABB_CCDD);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk_head("byte3", 32'h0000_1000, 32'hDDDD_DDDD, 4'b1000);
        tick();
        chk("byte3_drain", 32'(out_valid), 32'd0);

        // half then word, with push+pop in ONE
        drive(1'b1, 2'b01, 32'h0000_2002, 32'h1234_5678);
        tick();
        drive(1'b1, 2'b10, 32'h0000_3000, 32'h1234_5678);
        chk_head("half2", 32'h0000_2000, 32'h5678_5678, 4'b1100);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk_head("word", 32'h0000_3000, 32'h1234_5678, 4'b1111);
        tick();
        chk("word_drain", 32'(out_valid), 32'd0);

        // misaligned half, then illegal size
        drive(1'b1, 2'b01, 32'h0000_2001, 32'h1111_2222);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("mis_err", 32'(align_err), 32'd1);
        chk("mis_addr", err_addr, 32'h0000_2001);
        chk("mis_cause", 32'(err_cause), 32'd0);
        chk("mis_no_push", 32'(out_valid), 32'd0);
        tick();
        chk("mis_pulse_end", 32'(align_err), 32'd0);
        chk("mis_addr_hold", err_addr, 32'h0000_2001);
        drive(1'b1, 2'b11, 32'h0000_4000, 32'h0);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("ill_err", 32'(align_err), 32'd1);
        chk("ill_addr", err_addr, 32'h0000_4000);
        chk("ill_cause", 32'(err_cause), 32'd1);
        chk("ill_no_push", 32'(out_valid), 32'd0);
        tick();

        // backpressure with A, B, C
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 32'h0000_5000, 32'h1111_1111);
        tick();
        drive(1'b1, 2'b00, 32'h0000_5005, 32'h0000_0022);
        chk("b_in_ready", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 2'b01, 32'h0000_500A, 32'h0000_3333);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk_head("stallA0", 32'h0000_5000, 32'h1111_1111, 4'b1111);
        tick();
        chk_head("stallA1", 32'h0000_5000, 32'h1111_1111, 4'b1111);
        out_ready = 1'b1;
        tick();
        chk_head("B", 32'h0000_5004, 32'h2222_2222, 4'b0010);
        chk("c_in_ready", 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk_head("C", 32'h0000_5008, 32'h3333_3333, 4'b1100);
        tick();
        chk("abc_drain", 32'(out_valid), 32'd0);

        // flush while FULL, with both a legal and an illegal request presented
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 32'h0000_6000, 32'hD0D0_D0D0);
        tick();
        drive(1'b1, 2'b10, 32'h0000_6004, 32'hE0E0_E0E0);
        tick();
        drive(1'b1, 2'b10, 32'h0000_6008, 32'hF0F0_F0F0);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_err", 32'(align_err), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 2'b11, 32'h0000_7000, 32'h0);
        tick();
        chk("flush_ill_err", 32'(align_err), 32'd0);
        chk("flush_ill_addr", err_addr, 32'h0000_4000);
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        chk("flush_no_ghost", 32'(out_valid), 32'd0);

        // reset mid-operation clears head and error state
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 32'h0000_8000, 32'h8888_8888);
        tick();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_wdata", out_wdata, 32'h0);
        chk("mid_rst_be", 32'(out_be), 32'h0);
        chk("mid_rst_err_addr", err_addr, 32'h0);
        chk("mid_rst_cause", 32'(err_cause), 32'd0);
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
